stream_arb_2x1: RTL and testbench

- Two-input round-robin stream arbiter with packet locking and a registered output stage.
- Sits directly upstream of the 2:1 data mux: merges two valid/ready beat streams into one.
- Exports the granted input index on out_sel so the downstream mux and its select/data checks see a stable, registered select.
- Embedded SVA checks cover the handshake rules.

---
 rtl/stream_arb_pkg.sv | 14 +
 rtl/rr_grant_2.sv | 30 +++
 rtl/stream_arb_2x1.sv | 111 +++++++++++
 tb/tb_stream_arb_2x1.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types for the two-input stream arbiter: FSM state and input select encoding.
package stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef logic sel_t;

  localparam sel_t SEL_IN0 = 1'b0;
  localparam sel_t SEL_IN1 = 1'b1;

endpackage

// File: rtl/rr_grant_2.sv
// Combinational round-robin grant for two requesters, with packet-lock override.
module rr_grant_2
  import stream_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  sel_t       prio,
  input  arb_state_t state,
  input  sel_t       lock_sel,
  output logic       grant0,
  output logic       grant1
);

  // While locked the grant stays on the packet owner even if it has no beat ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == LOCKED) begin
      grant0 = (lock_sel == SEL_IN0);
      grant1 = (lock_sel == SEL_IN1);
    end else if (valid0 && valid1) begin
      grant0 = (prio == SEL_IN0);
      grant1 = (prio == SEL_IN1);
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

endmodule

// File: rtl/stream_arb_2x1.sv
// Two-input round-robin stream arbiter with optional packet locking and a
// registered output beat that also exports the index of the granted input.
module stream_arb_2x1
  import stream_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  arb_state_t        state;
  sel_t              prio;
  sel_t              lock_sel;
  logic              grant0;
  logic              grant1;
  logic              load_en;
  logic              acc0;
  logic              acc1;
  logic              accept;
  sel_t              acc_sel;
  logic [DATA_W-1:0] acc_data;
  logic              acc_last;

  rr_grant_2 u_grant (
    .valid0   (in0_valid),
    .valid1   (in1_valid),
    .prio     (prio),
    .state    (state),
    .lock_sel (lock_sel),
    .grant0   (grant0),
    .grant1   (grant1)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign load_en   = !out_valid || out_ready;
  assign in0_ready = grant0 && load_en;
  assign in1_ready = grant1 && load_en;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;
  assign accept    = acc0 || acc1;
  assign acc_sel   = acc1 ? SEL_IN1 : SEL_IN0;
  assign acc_data  = acc1 ? in1_data : in0_data;
  assign acc_last  = acc1 ? in1_last : in0_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= SEL_IN0;
      prio      <= SEL_IN0;
      lock_sel  <= SEL_IN0;
      state     <= IDLE;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_last  <= acc_last;
        out_sel   <= acc_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Priority moves past the winner at packet end (or every beat when unlocked).
      if (accept) begin
        if (!LOCK_PKT) begin
          prio <= ~acc_sel;
        end else if (acc_last) begin
          prio  <= ~acc_sel;
          state <= IDLE;
        end else if (state == IDLE) begin
          state    <= LOCKED;
          lock_sel <= acc_sel;
        end
      end
    end
  end

  a_stable_when_stalled : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_last) && $stable(out_sel)));

  a_one_hot_ready : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in0_ready && in1_ready));

  a_locked_other_blocked : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == LOCKED) |-> ((lock_sel == SEL_IN0) ? !in1_ready : !in0_ready));

  a_empty_after_reset : assert property (
    @(posedge clk)
    $rose(rst_n) |-> !out_valid);

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Directed bench for stream_arb_2x1: expected beats are queued as they are driven
// and checked by a monitor whenever the output handshake completes.
module tb_stream_arb_2x1;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in0_valid;
  logic              in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in0_last;
  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in1_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_sel;

  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_beat;

  always #5 clk = ~clk;

  stream_arb_2x1 #(.DATA_W(DATA_W), .LOCK_PKT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic l0,
                               input logic v1, input logic [7:0] d1, input logic l1,
                               input logic ordy);
    in0_valid = v0;
    in0_data  = d0;
    in0_last  = l0;
    in1_valid = v1;
    in1_data  = d1;
    in1_last  = l1;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed output handshake must match the oldest queued beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", {6'd0, out_sel, out_last, out_data}, 16'hFFFF);
      end else begin
        exp_beat = sb.pop_front();
        checkOutput("beat", {6'd0, out_sel, out_last, out_data}, {6'd0, exp_beat});
      end
    end
  end

  initial begin
    logic w;
    int   c0;
    int   c1;

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_out_data", 16'(out_data), 16'h0);
    checkOutput("rst_out_last", 16'(out_last), 16'h0);
    checkOutput("rst_out_sel", 16'(out_sel), 16'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_out_valid", 16'(out_valid), 16'h0);
      checkOutput("idle_out_sel", 16'(out_sel), 16'h0);
      checkOutput("idle_in0_ready", 16'(in0_ready), 16'h0);
      checkOutput("idle_in1_ready", 16'(in1_ready), 16'h0);
    end

    $display("[TB] single beat on in0");
    tick();
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    sb.push_back({1'b0, 1'b1, 8'hA5});
    @(negedge clk);
    checkOutput("single_in0_ready", 16'(in0_ready), 16'h1);
    checkOutput("single_in1_ready", 16'(in1_ready), 16'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("single_out_valid", 16'(out_valid), 16'h1);
    checkOutput("single_out_data", 16'(out_data), 16'hA5);
    checkOutput("single_out_sel", 16'(out_sel), 16'h0);
    checkOutput("single_out_last", 16'(out_last), 16'h1);
    tick();
    @(negedge clk);
    checkOutput("single_drained", 16'(out_valid), 16'h0);

    // The single in0 beat moved priority to in1, so in1 wins the first contested cycle.
    $display("[TB] alternating single-beat packets");
    c0 = 0;
    c1 = 0;
    w  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(1'b1, 8'(8'h10 + c0), 1'b1, 1'b1, 8'(8'h80 + c1), 1'b1, 1'b1);
      sb.push_back({w, 1'b1, (w ? 8'(8'h80 + c1) : 8'(8'h10 + c0))});
      @(negedge clk);
      checkOutput("alt_in0_ready", 16'(in0_ready), 16'(!w));
      checkOutput("alt_in1_ready", 16'(in1_ready), 16'(w));
      if (w) c1++;
      else c0++;
      w = ~w;
    end
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("alt_last_data", 16'(out_data), 16'h11);
    checkOutput("alt_last_sel", 16'(out_sel), 16'h0);

    $display("[TB] locked 3-beat packet on in0");
    tick();
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    sb.push_back({1'b0, 1'b0, 8'h01});
    @(negedge clk);
    checkOutput("lock_b1_in0_ready", 16'(in0_ready), 16'h1);
    tick();
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 8'h90, 1'b1, 1'b1);
    sb.push_back({1'b0, 1'b0, 8'h02});
    @(negedge clk);
    checkOutput("lock_b2_in0_ready", 16'(in0_ready), 16'h1);
    checkOutput("lock_b2_in1_ready", 16'(in1_ready), 16'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h90, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("lock_gap_in1_ready", 16'(in1_ready), 16'h0);
    tick();
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 8'h90, 1'b1, 1'b1);
    sb.push_back({1'b0, 1'b1, 8'h03});
    @(negedge clk);
    checkOutput("lock_b3_in0_ready", 16'(in0_ready), 16'h1);
    checkOutput("lock_b3_in1_ready", 16'(in1_ready), 16'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h90, 1'b1, 1'b1);
    sb.push_back({1'b1, 1'b1, 8'h90});
    @(negedge clk);
    checkOutput("unlock_in1_ready", 16'(in1_ready), 16'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("unlock_out_sel", 16'(out_sel), 16'h1);
    checkOutput("unlock_out_data", 16'(out_data), 16'h90);

    $display("[TB] stall with out_ready low");
    tick();
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sb.push_back({1'b0, 1'b1, 8'h5A});
    @(negedge clk);
    checkOutput("stall_load_in0_ready", 16'(in0_ready), 16'h1);
    tick();
    applyStimulus(1'b1, 8'h5B, 1'b1, 1'b1, 8'h9A, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", 16'(out_valid), 16'h1);
      checkOutput("stall_out_data", 16'(out_data), 16'h5A);
      checkOutput("stall_out_sel", 16'(out_sel), 16'h0);
      checkOutput("stall_out_last", 16'(out_last), 16'h1);
      checkOutput("stall_in0_ready", 16'(in0_ready), 16'h0);
      checkOutput("stall_in1_ready", 16'(in1_ready), 16'h0);
      tick();
    end
    applyStimulus(1'b1, 8'h5B, 1'b1, 1'b1, 8'h9A, 1'b1, 1'b1);
    sb.push_back({1'b1, 1'b1, 8'h9A});
    @(negedge clk);
    checkOutput("release_in1_ready", 16'(in1_ready), 16'h1);
    checkOutput("release_in0_ready", 16'(in0_ready), 16'h0);
    tick();
    applyStimulus(1'b1, 8'h5B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    sb.push_back({1'b0, 1'b1, 8'h5B});
    @(negedge clk);
    checkOutput("release_next_data", 16'(out_data), 16'h9A);
    checkOutput("release_next_sel", 16'(out_sel), 16'h1);
    checkOutput("passthru_in0_ready", 16'(in0_ready), 16'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("passthru_out_valid", 16'(out_valid), 16'h1);
    checkOutput("passthru_out_data", 16'(out_data), 16'h5B);

    $display("[TB] reset in the middle of an in1 packet");
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1);
    sb.push_back({1'b1, 1'b0, 8'hC1});
    @(negedge clk);
    checkOutput("midpkt_in1_ready", 16'(in1_ready), 16'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midpkt_locked_in1_ready", 16'(in1_ready), 16'h1);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    checkOutput("midpkt_rst_out_valid", 16'(out_valid), 16'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    sb.push_back({1'b0, 1'b1, 8'h33});
    @(negedge clk);
    checkOutput("postrst_in0_ready", 16'(in0_ready), 16'h1);
    checkOutput("postrst_in1_ready", 16'(in1_ready), 16'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("postrst_out_data", 16'(out_data), 16'h33);
    checkOutput("postrst_out_sel", 16'(out_sel), 16'h0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("sb_empty", 16'(sb.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
